// File: rtl/piso_frame_serializer.sv
// Parallel-in serial-out framer feeding a SISO stage over Serial_OUT/Load.
// Optional even-parity trailer bit: define PARITY_BIT_EN.
module piso_frame_serializer #(
  parameter int WIDTH      = 4,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] Data_IN,
  input  logic             Data_Valid,
  output logic             Data_Ready,
  output logic             Serial_OUT,
  output logic             Load,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH + 1);
`ifdef PARITY_BIT_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam logic [CW-1:0] LAST = CW'(NBITS - 1);
  localparam logic [3:0] GAP_LAST =
    (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic [CW-1:0]    bcnt, bcnt_n;
  logic [3:0]       gcnt, gcnt_n;
  logic             sout_n, load_n, busy_n, done_n;
  logic             accept;
`ifdef PARITY_BIT_EN
  logic             par, par_n;
`endif

  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // Ready is decoded from state so the handshake needs no extra cycle
  assign Data_Ready = (state == IDLE) && !RST;
  assign accept     = Data_Valid && Data_Ready;

  always_comb begin
    state_n = state;
    sr_n    = sr;
    bcnt_n  = bcnt;
    gcnt_n  = gcnt;
    sout_n  = 1'b0;
    load_n  = 1'b0;
    done_n  = 1'b0;
`ifdef PARITY_BIT_EN
    par_n   = par;
`endif
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_n = SHIFT;
          sr_n    = Data_IN;
          bcnt_n  = '0;
          sout_n  = head(Data_IN);
          load_n  = 1'b1;
`ifdef PARITY_BIT_EN
          par_n   = ^Data_IN;
`endif
        end
      end
      SHIFT: begin
        if (bcnt == LAST) begin
          done_n  = 1'b1;
          gcnt_n  = 4'd0;
          state_n = (GAP_CYCLES > 0) ? GAP : IDLE;
        end else begin
          bcnt_n = bcnt + 1'b1;
          sr_n   = adv(sr);
          load_n = 1'b1;
          sout_n = head(adv(sr));
`ifdef PARITY_BIT_EN
          if (bcnt == CW'(WIDTH - 1)) sout_n = par;
`endif
        end
      end
      GAP: begin
        if (gcnt == GAP_LAST) state_n = IDLE;
        else gcnt_n = gcnt + 4'd1;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      sr         <= '0;
      bcnt       <= '0;
      gcnt       <= 4'd0;
      Serial_OUT <= 1'b0;
      Load       <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
    end else begin
      state      <= state_n;
      sr         <= sr_n;
      bcnt       <= bcnt_n;
      gcnt       <= gcnt_n;
      Serial_OUT <= sout_n;
      Load       <= load_n;
      Busy       <= busy_n;
      Done       <= done_n;
    end
  end

`ifdef PARITY_BIT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) par <= 1'b0;
    else     par <= par_n;
  end
`endif

endmodule

// File: tb/tb_piso_frame_serializer.sv
// Directed bench for piso_frame_serializer: three configurations
// (MSB/gap1, LSB/gap1, MSB/gap0) sharing clock and reset.
module tb_piso_frame_serializer;

`ifdef PARITY_BIT_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] din0, din1, din2;
  logic       v0, v1, v2;
  logic       rdy0, so0, ld0, bsy0, dn0;
  logic       rdy1, so1, ld1, bsy1, dn1;
  logic       rdy2, so2, ld2, bsy2, dn2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  piso_frame_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP_CYCLES(1)) u0 (
    .CLK(CLK), .RST(RST), .Data_IN(din0), .Data_Valid(v0),
    .Data_Ready(rdy0), .Serial_OUT(so0), .Load(ld0), .Busy(bsy0), .Done(dn0)
  );

  piso_frame_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .GAP_CYCLES(1)) u1 (
    .CLK(CLK), .RST(RST), .Data_IN(din1), .Data_Valid(v1),
    .Data_Ready(rdy1), .Serial_OUT(so1), .Load(ld1), .Busy(bsy1), .Done(dn1)
  );

  piso_frame_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) u2 (
    .CLK(CLK), .RST(RST), .Data_IN(din2), .Data_Valid(v2),
    .Data_Ready(rdy2), .Serial_OUT(so2), .Load(ld2), .Busy(bsy2), .Done(dn2)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // bits: transmit order, first bit in [3]; par: hand-computed parity
  function automatic logic [4:0] seq_of(input logic [3:0] bits,
                                        input logic par);
`ifdef PARITY_BIT_EN
    return {bits, par};
`else
    return {par & 1'b0, bits};
`endif
  endfunction

  task automatic send0(input logic [3:0] data, input logic [3:0] bits,
                       input logic par);
    logic [4:0] s;
    logic [4:0] got, exp;
    logic [3:0] q;
    s = seq_of(bits, par);
    q = 4'd0;
    din0 = data;
    v0   = 1'b1;
    n_tests++;
    if (rdy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL send0_ready got %b want 1", rdy0);
    end
    tick();
    v0   = 1'b0;
    din0 = ~data;
    for (int i = 0; i < NB; i++) begin
      got = {ld0, so0, dn0, rdy0, bsy0};
      exp = {1'b1, s[NB-1-i], 1'b0, 1'b0, 1'b1};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL send0_bit%0d ld/so/dn/rdy/bsy got %b want %b",
                 i, got, exp);
      end
      if (i < 4) q = {q[2:0], so0};
      tick();
    end
    got = {ld0, so0, dn0, rdy0, bsy0};
    exp = 5'b00101;
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL send0_done got %b want %b", got, exp);
    end
    n_tests++;
    if (q !== data) begin
      n_fail++;
      $display("FAIL send0_siso_q got %b want %b", q, data);
    end
    tick();
    got = {ld0, so0, dn0, rdy0, bsy0};
    exp = 5'b00010;
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL send0_idle got %b want %b", got, exp);
    end
  endtask

  task automatic test_reset();
    logic [7:0] got;
    RST = 1'b1;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    din0 = 4'd0; din1 = 4'd0; din2 = 4'd0;
    #3;
    got = {ld0, so0, bsy0, dn0, ld1, so1, ld2, so2};
    n_tests++;
    if (got !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got %b want 00000000", got);
    end
    #9;
    RST = 1'b0;
    tick();
    n_tests++;
    if ({rdy0, rdy1, rdy2, bsy0, dn0} !== 5'b11100) begin
      n_fail++;
      $display("FAIL reset_ready got %b want 11100",
               {rdy0, rdy1, rdy2, bsy0, dn0});
    end
  endtask

  task automatic test_msb_word();
    send0(4'b1011, 4'b1011, 1'b1);
    send0(4'b1001, 4'b1001, 1'b0);
  endtask

  task automatic test_lsb_word();
    logic [4:0] s;
    logic [3:0] got, exp;
    s = seq_of(4'b0110, 1'b0);
    din1 = 4'b0110;
    v1   = 1'b1;
    tick();
    v1 = 1'b0;
    for (int p = 0; p <= NB + 1; p++) begin
      exp = {p < NB, (p < NB) ? s[NB-1-p] : 1'b0, p == NB, p == NB + 1};
      got = {ld1, so1, dn1, rdy1};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL lsb p=%0d ld/so/dn/rdy got %b want %b", p, got, exp);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] s1, s2;
    logic [3:0] got, exp;
    logic       e_ld, e_so;
    s1 = seq_of(4'b0101, 1'b0);
    s2 = seq_of(4'b1010, 1'b0);
    din1 = 4'hA;
    v1   = 1'b1;
    tick();
    din1 = 4'h5;
    for (int p = 0; p <= 2 * NB + 3; p++) begin
      e_ld = 1'b0;
      e_so = 1'b0;
      if (p < NB) begin
        e_ld = 1'b1;
        e_so = s1[NB-1-p];
      end else if (p >= NB + 2 && p < 2 * NB + 2) begin
        e_ld = 1'b1;
        e_so = s2[NB-1-(p-NB-2)];
      end
      exp = {e_ld, e_so, (p == NB) || (p == 2 * NB + 2),
             (p == NB + 1) || (p == 2 * NB + 3)};
      got = {ld1, so1, dn1, rdy1};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL b2b p=%0d ld/so/dn/rdy got %b want %b", p, got, exp);
      end
      if (p == NB + 2) v1 = 1'b0;
      tick();
    end
  endtask

  task automatic test_busy_ignore();
    logic [4:0] s;
    logic [4:0] got, exp;
    s = seq_of(4'b1011, 1'b1);
    din0 = 4'b1011;
    v0   = 1'b1;
    tick();
    v0 = 1'b0;
    for (int p = 0; p <= NB + 2; p++) begin
      exp = {p < NB, (p < NB) ? s[NB-1-p] : 1'b0, p == NB,
             p >= NB + 1, p <= NB};
      got = {ld0, so0, dn0, rdy0, bsy0};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL busy p=%0d ld/so/dn/rdy/bsy got %b want %b",
                 p, got, exp);
      end
      if (p == 1) begin
        v0   = 1'b1;
        din0 = 4'hF;
      end
      if (p == 3) v0 = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset_midword();
    din0 = 4'b1101;
    v0   = 1'b1;
    tick();
    v0 = 1'b0;
    n_tests++;
    if ({ld0, so0} !== 2'b11) begin
      n_fail++;
      $display("FAIL rstmid_bit0 got %b want 11", {ld0, so0});
    end
    tick();
    n_tests++;
    if ({ld0, so0} !== 2'b11) begin
      n_fail++;
      $display("FAIL rstmid_bit1 got %b want 11", {ld0, so0});
    end
    #3;
    RST = 1'b1;
    #1;
    n_tests++;
    if ({ld0, so0, dn0, bsy0} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rstmid_async got %b want 0000", {ld0, so0, dn0, bsy0});
    end
    tick();
    n_tests++;
    if ({ld0, dn0} !== 2'b00) begin
      n_fail++;
      $display("FAIL rstmid_hold got %b want 00", {ld0, dn0});
    end
    #3;
    RST = 1'b0;
    #1;
    n_tests++;
    if (rdy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_ready got %b want 1", rdy0);
    end
    send0(4'b0011, 4'b0011, 1'b0);
  endtask

  task automatic test_gap0();
    logic [4:0] s1, s2;
    logic [3:0] got, exp;
    logic       e_ld, e_so;
    int         dcount, lowcnt;
    s1 = seq_of(4'b1100, 1'b0);
    s2 = seq_of(4'b0011, 1'b0);
    dcount = 0;
    lowcnt = 0;
    din2 = 4'hC;
    v2   = 1'b1;
    tick();
    din2 = 4'h3;
    for (int p = 0; p <= 2 * NB + 2; p++) begin
      e_ld = 1'b0;
      e_so = 1'b0;
      if (p < NB) begin
        e_ld = 1'b1;
        e_so = s1[NB-1-p];
      end else if (p > NB && p <= 2 * NB) begin
        e_ld = 1'b1;
        e_so = s2[NB-1-(p-NB-1)];
      end
      exp = {e_ld, e_so, (p == NB) || (p == 2 * NB + 1),
             (p == NB) || (p >= 2 * NB + 1)};
      got = {ld2, so2, dn2, rdy2};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL gap0 p=%0d ld/so/dn/rdy got %b want %b", p, got, exp);
      end
      if (dn2 === 1'b1) dcount++;
      if (p > 0 && p < 2 * NB && ld2 !== 1'b1) lowcnt++;
      if (p == NB + 1) v2 = 1'b0;
      tick();
    end
    n_tests++;
    if (dcount !== 2) begin
      n_fail++;
      $display("FAIL gap0_done_count got %0d want 2", dcount);
    end
    n_tests++;
    if (lowcnt !== 1) begin
      n_fail++;
      $display("FAIL gap0_load_gap got %0d want 1", lowcnt);
    end
  endtask

  initial begin
    test_reset();
    test_msb_word();
    test_lsb_word();
    test_back_to_back();
    test_busy_ignore();
    test_reset_midword();
    test_gap0();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_frame_serializer.md
Name: piso_frame_serializer

Overview:
Upstream feeder for the 4-bit SISO shift register stage. Accepts a parallel word over a valid/ready handshake and serializes it one bit per clock. Drives Serial_OUT plus a Load (shift-enable) qualifier that connect directly to the SISO stage's Serial_IN/Load inputs. Load stays high only while the bits of a word are valid; an inter-word gap holds the downstream stage.

Parameters:
WIDTH, 4, bits per parallel word (>=2)
MSB_FIRST, 1, 1 = transmit Data_IN[WIDTH-1] first; 0 = LSB first
GAP_CYCLES, 1, idle cycles with Load=0 after each word (0..15)

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous, active-high reset
Data_IN  input  WIDTH  parallel word; sampled only on handshake
Data_Valid  input  1  upstream word available
Data_Ready  output  1  serializer can accept a word (high only in IDLE)
Serial_OUT  output  1  serial bit to the downstream SISO Serial_IN
Load  output  1  shift enable to the downstream SISO; high when Serial_OUT is a valid bit
Busy  output  1  high in SHIFT or GAP
Done  output  1  one-cycle pulse after the final bit of a word

Behaviour:
- Reset (async, RST=1): state=IDLE, shift reg=0, bit counter=0, gap counter=0. Outputs: Serial_OUT=0, Load=0, Busy=0, Done=0, Data_Ready=1 once RST deasserts.
- All outputs are registered, except Data_Ready, which is decoded from state.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - Data_Ready=1, Load=0, Serial_OUT=0.
  - On the edge where Data_Valid & Data_Ready: capture Data_IN, clear the bit counter, go to SHIFT.
- SHIFT:
  - Load=1.
  - Serial_OUT = current head bit (MSB or LSB per MSB_FIRST); the register shifts one place per edge.
  - The first bit appears in the cycle right after the handshake edge (latency 1).
  - Exactly WIDTH consecutive Load-high cycles per word.
  - After the last bit: go to GAP if GAP_CYCLES>0, else IDLE.
- GAP:
  - Load=0, Serial_OUT=0.
  - Counts GAP_CYCLES cycles, then goes to IDLE.
- Done: high for exactly one cycle, the cycle after the last Load-high cycle, regardless of GAP_CYCLES.
- Throughput: with GAP_CYCLES=0, a new handshake is possible in the cycle after the last bit. Minimum word period is WIDTH+1+GAP_CYCLES cycles.
- Data_Valid while Busy: ignored (Data_Ready=0). Upstream must hold Data_IN/Data_Valid until the handshake.
- Data_IN changes during SHIFT: no effect on the word in flight.
- Reset mid-word: immediate abort. Load and Serial_OUT drop asynchronously, the partial word is discarded, no Done.
- Counter widths: bit counter $clog2(WIDTH+1); gap counter 4 bits. No wrap inside a word.

Optional Feature:
PARITY_BIT_EN
- Defined: one even-parity bit (XOR of all captured data bits) is appended after the data bits in SHIFT, with Load=1. A word is then WIDTH+1 Load-high cycles, and Done follows the parity cycle. Minimum word period becomes WIDTH+2+GAP_CYCLES.
- Undefined: no parity logic; behaviour exactly as above.

Test Plan:
1. WIDTH=4, MSB_FIRST=1, GAP=1: handshake with Data_IN=4'b1011 -> Serial_OUT 1,0,1,1 on the next 4 cycles with Load=1. Then Done=1 for one cycle, Load=0 for 1 gap cycle, Data_Ready=1. Downstream SISO q=4'b1011 after the last shift.
2. MSB_FIRST=0, Data_IN=4'b0110 -> Serial_OUT 0,1,1,0. Data_Valid held high for back-to-back words 4'hA then 4'h5 -> second word starts exactly WIDTH+1+GAP cycles after the first handshake; no bit lost or repeated.
3. Data_Valid pulsed during SHIFT with Data_IN=4'hF -> ignored; in-flight word unchanged; Data_Ready=0 throughout.
4. RST asserted after the 2nd bit of 4'b1101 -> Load=0, Serial_OUT=0 immediately (before the next edge), no Done. After release, Data_Ready=1 and the next word 4'b0011 serializes correctly.
5. PARITY_BIT_EN defined, Data_IN=4'b1011 -> 5 Load-high cycles: 1,0,1,1,1 (parity=1). Data_IN=4'b1001 -> parity bit 0.
6. GAP_CYCLES=0 with continuous Data_Valid -> Load low for exactly 1 cycle between words; Done pulses once per word.
